// File: rtl/mac_seq.sv
// Sequential 4x4-bit unsigned multiply-accumulate engine: takes len operand
// pairs over a valid/ready input, then holds the dot product until it is accepted.
module mac_seq #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy,
    output logic [LEN_W-1:0] count,
    output logic [1:0]       state_dbg
);

    // Handshakes: a pair moves on a rising edge with in_valid && in_ready; the
    // result is offered with y_valid and retired on a rising edge with y_ready.
    // in_ready and y_valid depend on the state register only.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       op_a_q, op_a_d;
    logic [3:0]       op_b_q, op_b_d;
    logic             stage_v_q, stage_v_d;
    logic [7:0]       prod;
    logic [LEN_W-1:0] count_inc;

    assign prod      = op_a_q * op_b_q;
    assign count_inc = count_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        acc_d     = acc_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        stage_v_d = 1'b0;

        // Second pipeline stage: fold in the product captured one edge earlier.
        if (stage_v_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    count_d = '0;
                    acc_d   = '0;
                    state_d = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (in_valid) begin
                    op_a_d    = a_in;
                    op_b_d    = b_in;
                    stage_v_d = 1'b1;
                    count_d   = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                // A start seen together with y_ready is dropped on purpose.
                if (y_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            stage_v_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            stage_v_q <= stage_v_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign y_valid   = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = acc_q;
    assign count     = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: one task per scenario with hand-computed
// expected results, inline comparisons and a single summary line.
module tb_mac_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic [3:0]  a_in;
    logic [3:0]  b_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] y;
    logic        y_valid;
    logic        y_ready;
    logic        busy;
    logic [3:0]  count;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    mac_seq #(.LEN_W(4), .ACC_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .busy      (busy),
        .count     (count),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle so registered outputs are stable
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got in_ready=%b y_valid=%b busy=%b exp 0 0 0", in_ready, y_valid, busy);
        end
        checks++;
        if (y !== 12'd0 || count !== 4'd0) begin
            failures++;
            $display("FAIL reset_data got y=%0d count=%0d exp 0 0", y, count);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b in_ready=%b exp 0 0", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        len = 4'd3;
        tick();
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || count !== 4'd0) begin
            failures++;
            $display("FAIL b2b_run got in_ready=%b busy=%b count=%0d exp 1 1 0", in_ready, busy, count);
        end
        send_pair(4'd2, 4'd3);
        in_valid = 1'b1;
        send_pair(4'd4, 4'd5);
        in_valid = 1'b1;
        send_pair(4'd15, 4'd15);
        // one cycle after the last transfer: draining, not yet valid
        checks++;
        if (y_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || count !== 4'd3) begin
            failures++;
            $display("FAIL b2b_drain got y_valid=%b in_ready=%b busy=%b count=%0d exp 0 0 1 3", y_valid, in_ready, busy, count);
        end
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd251 || count !== 4'd3) begin
            failures++;
            $display("FAIL b2b_result got y_valid=%b y=%0d count=%0d exp 1 251 3", y_valid, y, count);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        checks++;
        if (y_valid !== 1'b0 || busy !== 1'b0 || y !== 12'd251 || count !== 4'd3) begin
            failures++;
            $display("FAIL b2b_retire got y_valid=%b busy=%b y=%0d count=%0d exp 0 0 251 3", y_valid, busy, y, count);
        end
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len = 4'd0;
        tick();
        start = 1'b0;
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd0 || in_ready !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL len0_result got y_valid=%b y=%0d in_ready=%b count=%0d exp 1 0 0 0", y_valid, y, in_ready, count);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0_retire got busy=%b in_ready=%b exp 0 0", busy, in_ready);
        end
    endtask

    task automatic test_stall();
        start = 1'b1;
        len = 4'd15;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            send_pair(4'd15, 4'd15);
            checks++;
            if (count !== 4'(i + 1)) begin
                failures++;
                $display("FAIL stall_xfer_count i=%0d got %0d exp %0d", i, count, i + 1);
            end
            if (i < 14) begin
                tick();
                checks++;
                if (count !== 4'(i + 1) || in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_gap i=%0d got count=%0d in_ready=%b exp %0d 1", i, count, in_ready, i + 1);
                end
            end
        end
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd3375 || count !== 4'd15) begin
            failures++;
            $display("FAIL stall_result got y_valid=%b y=%0d count=%0d exp 1 3375 15", y_valid, y, count);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic test_hold();
        start = 1'b1;
        len = 4'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        send_pair(4'd3, 4'd4);
        in_valid = 1'b1;
        send_pair(4'd5, 4'd6);
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd42) begin
            failures++;
            $display("FAIL hold_result got y_valid=%b y=%0d exp 1 42", y_valid, y);
        end
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len = 4'd5;
            tick();
            checks++;
            if (y_valid !== 1'b1 || y !== 12'd42 || busy !== 1'b1 || in_ready !== 1'b0 || count !== 4'd2) begin
                failures++;
                $display("FAIL hold_cycle i=%0d got y_valid=%b y=%0d busy=%b in_ready=%b count=%0d exp 1 42 1 0 2",
                         i, y_valid, y, busy, in_ready, count);
            end
        end
        start = 1'b0;
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        checks++;
        if (y_valid !== 1'b0 || busy !== 1'b0 || y !== 12'd42) begin
            failures++;
            $display("FAIL hold_retire got y_valid=%b busy=%b y=%0d exp 0 0 42", y_valid, busy, y);
        end
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1;
        len = 4'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        send_pair(4'd1, 4'd2);
        in_valid = 1'b1;
        send_pair(4'd3, 4'd4);
        // assert reset between clock edges and look before any edge arrives
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0 || y !== 12'd0 || count !== 4'd0) begin
            failures++;
            $display("FAIL rst_async got in_ready=%b y_valid=%b busy=%b y=%0d count=%0d exp 0 0 0 0 0",
                     in_ready, y_valid, busy, y, count);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle got busy=%b exp 0", busy);
        end
        start = 1'b1;
        len = 4'd1;
        tick();
        start = 1'b0;
        send_pair(4'd7, 4'd9);
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd63 || count !== 4'd1) begin
            failures++;
            $display("FAIL rst_newjob got y_valid=%b y=%0d count=%0d exp 1 63 1", y_valid, y, count);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic test_start_in_done();
        start = 1'b1;
        len = 4'd1;
        tick();
        start = 1'b0;
        send_pair(4'd2, 4'd2);
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd4) begin
            failures++;
            $display("FAIL sid_result got y_valid=%b y=%0d exp 1 4", y_valid, y);
        end
        start = 1'b1;
        len = 4'd2;
        y_ready = 1'b1;
        tick();
        start = 1'b0;
        y_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || y_valid !== 1'b0 || in_ready !== 1'b0 || y !== 12'd4 || count !== 4'd1) begin
            failures++;
            $display("FAIL sid_ignored got busy=%b y_valid=%b in_ready=%b y=%0d count=%0d exp 0 0 0 4 1",
                     busy, y_valid, in_ready, y, count);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL sid_no_job got busy=%b exp 0", busy);
        end
        start = 1'b1;
        len = 4'd1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || count !== 4'd0 || y !== 12'd0) begin
            failures++;
            $display("FAIL sid_restart got busy=%b in_ready=%b count=%0d y=%0d exp 1 1 0 0", busy, in_ready, count, y);
        end
        send_pair(4'd6, 4'd7);
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 12'd42 || count !== 4'd1) begin
            failures++;
            $display("FAIL sid_newjob got y_valid=%b y=%0d count=%0d exp 1 42 1", y_valid, y, count);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        len      = 4'd0;
        a_in     = 4'd0;
        b_in     = 4'd0;
        in_valid = 1'b0;
        y_ready  = 1'b0;

        test_reset();
        test_back_to_back();
        test_len_zero();
        test_stall();
        test_hold();
        test_reset_mid_job();
        test_start_in_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter LEN_W, default 4: width of the pair-count field; at most 2^LEN_W-1 pairs per job.
REQ-002 Parameter ACC_W, default 12: accumulator/result width; at default values the sum cannot overflow (15*225=3375).
REQ-003 Clock is clk; reset is rst, asynchronous and active-high; one clock domain.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  job request, sampled only in IDLE.
REQ-007 len  input  LEN_W  number of operand pairs in the job, latched on accepted start.
REQ-008 a_in  input  4  unsigned operand A.
REQ-009 b_in  input  4  unsigned operand B.
REQ-010 in_valid  input  1  a_in/b_in valid.
REQ-011 in_ready  output  1  block accepts a pair this cycle.
REQ-012 y  output  ACC_W  dot-product result.
REQ-013 y_valid  output  1  y valid, held until accepted.
REQ-014 y_ready  input  1  consumer accepts y.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 count  output  LEN_W  number of pairs accepted in the current job.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-018 Pair transfer: a pair SHALL transfer at a rising edge where in_valid=1 and in_ready=1; no other transfer exists.
REQ-019 in_ready SHALL equal 1 in RUN only; it is a function of state only, with no combinational path from in_valid.
REQ-020 IDLE, start=1: the block SHALL latch len, clear the accumulator and count to 0, and go to RUN if len!=0, else to DONE.
REQ-021 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-022 Operand stage: each transfer SHALL register a_in/b_in into operand registers, set a stage-valid flag, and increment count.
REQ-023 Accumulate stage: at the edge after a transfer, the accumulator SHALL add the full 8-bit unsigned product of the operand registers, zero-extended to ACC_W; the block SHALL add nothing when the stage-valid flag is 0.
REQ-024 RUN SHALL stay in RUN while count < latched len, and SHALL go to DRAIN at the edge of the transfer that makes count equal latched len.
REQ-025 DRAIN SHALL last exactly one cycle, in which the final product is accumulated, then go to DONE.
REQ-026 Latency: y_valid SHALL rise 2 cycles after the edge of the last transfer, and 1 cycle after an accepted start with len=0.
REQ-027 DONE: y_valid=1, and y SHALL equal the accumulator and stay stable until y_ready=1.
REQ-028 DONE with y_ready=1: the block SHALL go to IDLE at that edge; y_valid deasserts, while y and count hold their values until the next accepted start.
REQ-029 start=1 and y_ready=1 together in DONE: the block SHALL go to IDLE and ignore the start; the requester re-asserts start in IDLE.
REQ-030 Gaps in in_valid during RUN SHALL stall the job with no state change and no accumulation.
REQ-031 y_valid SHALL be 0 in all states except DONE.
REQ-032 Accumulation SHALL wrap modulo 2^ACC_W when parameters permit overflow; no overflow flag is provided.

Reset
REQ-033 Asserting rst SHALL immediately force state IDLE and set in_ready, y_valid and busy to 0, and y, count, the accumulator, the operand registers and the stage-valid flag to 0.
REQ-034 Reset mid-job SHALL discard the job; the first start after rst deasserts begins a fresh job.

Verification
REQ-035 start, len=3, pairs (2,3),(4,5),(15,15) back-to-back -> y_valid rises 2 cycles after the third transfer, y=251, count=3.
REQ-036 start, len=0 -> next cycle y_valid=1, y=0, in_ready never asserts.
REQ-037 len=15, all pairs (15,15), in_valid toggling 1/0 -> y=3375; cycles with in_valid=0 neither accumulate nor change count.
REQ-038 Job done, y_ready held low 5 cycles with start pulsed -> y stable and y_valid high throughout, start ignored; y_ready=1 -> IDLE next cycle.
REQ-039 rst asserted after 2 of 4 pairs of a job -> outputs 0 asynchronously; new job len=1 with pair (7,9) -> y=63.
REQ-040 start and y_ready both high in DONE -> IDLE, busy=0, no new job; start in the next cycle -> job runs normally.
